// File: rtl/cache_pkg.sv
// Shared types and constants for the cache line / burst memory adapter.
package cache_pkg;

    localparam int unsigned LINE_W   = 256;
    localparam int unsigned BEAT_W   = 64;
    localparam int unsigned BEATS    = 4;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned OFFSET_W = $clog2(LINE_W / 8);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR_DATA,
        RESP
    } state_e;

    // Clear the byte-offset bits so the address points at the start of a line.
    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/cacheline_adapter.sv
// Bridges whole-line read/write-back requests from the cache onto a
// beat-serial burst memory: a read fetches BEATS beats and assembles a line,
// a write-back streams the latched line out one beat per accepted cycle.
module cacheline_adapter #(
    parameter int unsigned BEATS  = 4,
    parameter int unsigned BEAT_W = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             dfp_addr,
    input  logic                    dfp_read,
    input  logic                    dfp_write,
    input  logic [BEATS*BEAT_W-1:0] dfp_wdata,
    output logic [BEATS*BEAT_W-1:0] dfp_rdata,
    output logic                    dfp_resp,
    output logic [31:0]             bmem_addr,
    output logic                    bmem_read,
    output logic                    bmem_write,
    output logic [BEAT_W-1:0]       bmem_wdata,
    input  logic                    bmem_ready,
    input  logic [31:0]             bmem_raddr,
    input  logic [BEAT_W-1:0]       bmem_rdata,
    input  logic                    bmem_rvalid
);
    import cache_pkg::*;

    localparam int unsigned LINE_BITS = BEATS * BEAT_W;
    localparam int unsigned CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [31:0]            addr_q, addr_d;
    // Holds the write-back line, or the read line while it is being assembled.
    logic [LINE_BITS-1:0]   line_q, line_d;
    // Completed read line; only replaced when the next read finishes.
    logic [LINE_BITS-1:0]   rdata_q, rdata_d;
    logic                   beat_hit;

    // Only beats tagged with the outstanding line address belong to this fill.
    assign beat_hit = bmem_rvalid && (bmem_raddr == addr_q);

    // Next-state and strobe decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        line_d     = line_q;
        rdata_d    = rdata_q;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        dfp_resp   = 1'b0;

        case (state_q)
            IDLE: begin
                // Write-back wins so a dirty victim leaves before the fill.
                if (dfp_write) begin
                    addr_d  = line_align(dfp_addr);
                    line_d  = dfp_wdata;
                    cnt_d   = '0;
                    state_d = WR_DATA;
                end else if (dfp_read) begin
                    addr_d  = line_align(dfp_addr);
                    cnt_d   = '0;
                    state_d = RD_REQ;
                end
            end

            RD_REQ: begin
                bmem_read = 1'b1;
                if (bmem_ready) begin
                    state_d = RD_DATA;
                end
            end

            RD_DATA: begin
                if (beat_hit) begin
                    line_d[32'(cnt_q) * BEAT_W +: BEAT_W] = bmem_rdata;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        rdata_d = line_d;
                        state_d = RESP;
                    end
                end
            end

            WR_DATA: begin
                bmem_write = 1'b1;
                if (bmem_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = RESP;
                    end
                end
            end

            RESP: begin
                dfp_resp = 1'b1;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and line registers; reset discards any partial burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            line_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
            rdata_q <= rdata_d;
        end
    end

    assign dfp_rdata  = rdata_q;
    assign bmem_addr  = addr_q;
    assign bmem_wdata = line_q[32'(cnt_q) * BEAT_W +: BEAT_W];

endmodule

// File: doc/cacheline_adapter.md
CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

Interface
REQ-001 SHALL have parameter BEATS, default 4: burst beats per cache line.
REQ-002 SHALL have parameter BEAT_W, default 64: burst beat width in bits; BEATS*BEAT_W SHALL equal 256.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port dfp_addr, input, 32: line address from the cache.
REQ-006 SHALL have port dfp_read, input, 1: line read request.
REQ-007 SHALL have port dfp_write, input, 1: line write-back request.
REQ-008 SHALL have port dfp_wdata, input, 256: write-back line.
REQ-009 SHALL have port dfp_rdata, output, 256: assembled read line.
REQ-010 SHALL have port dfp_resp, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port bmem_addr, output, 32: burst address, line-aligned.
REQ-012 SHALL have port bmem_read, output, 1: burst read command.
REQ-013 SHALL have port bmem_write, output, 1: burst write beat valid.
REQ-014 SHALL have port bmem_wdata, output, 64: write beat data.
REQ-015 SHALL have port bmem_ready, input, 1: memory accepts the command or beat this cycle.
REQ-016 SHALL have port bmem_raddr, input, 32: address tag of the returning read beat.
REQ-017 SHALL have port bmem_rdata, input, 64: read beat data.
REQ-018 SHALL have port bmem_rvalid, input, 1: read beat valid.

Function
REQ-019 SHALL implement the FSM states IDLE, RD_REQ, RD_DATA, WR_DATA and RESP.
REQ-020 In IDLE, dfp_write=1 SHALL latch {dfp_addr[31:5],5'b0} and dfp_wdata, clear the beat counter, and go to WR_DATA; write takes priority if dfp_read is also 1.
REQ-021 In IDLE, dfp_read=1 with dfp_write=0 SHALL latch the aligned address and go to RD_REQ.
REQ-022 RD_REQ SHALL hold bmem_read=1 and bmem_addr=latched address until a cycle with bmem_ready=1, then go to RD_DATA; bmem_read is asserted for exactly one accepted cycle.
REQ-023 RD_DATA SHALL accept a beat only when bmem_rvalid=1 and bmem_raddr equals the latched address; it places beat k in line bits [64k+63:64k], k=0..3 in arrival order.
REQ-024 Non-matching or out-of-state bmem_rvalid beats SHALL be ignored.
REQ-025 After the 4th beat, the FSM SHALL go to RESP; dfp_rdata SHALL be the full line from the RESP cycle onward and hold until the next read's RESP.
REQ-026 WR_DATA SHALL drive bmem_write=1, bmem_addr=latched address, and bmem_wdata=latched line bits [64k+63:64k] for counter k.
REQ-027 In WR_DATA, k SHALL advance only on cycles with bmem_ready=1; after beat 3 is accepted the FSM SHALL go to RESP.
REQ-028 RESP SHALL assert dfp_resp=1 for exactly one cycle and return to IDLE; dfp_read and dfp_write are ignored in RESP.
REQ-029 Outputs SHALL be bmem_read=bmem_write=0 in IDLE and RESP; bmem_addr and bmem_wdata are don't-care when their strobes are 0.
REQ-030 Minimum latency with bmem_ready=1 and back-to-back beats: write, request in cycle 0 and dfp_resp in cycle 5; read, dfp_resp in the cycle after the 4th beat.
REQ-031 Back-to-back requests (write-back then fill) SHALL be accepted in the IDLE cycle after RESP with no extra bubble.
REQ-032 The beat counter SHALL be 2 bits and wrap 3->0 only on a state change.

Reset
REQ-033 Asserting rst at any time, including mid-burst, SHALL force IDLE and zero the beat counter, dfp_resp, bmem_read and bmem_write.
REQ-034 Reset SHALL zero dfp_rdata, and partially assembled beats SHALL be discarded.
REQ-035 Beats arriving after reset deassertion SHALL be ignored because the FSM is in IDLE.

Structure
REQ-036 A shared package cache_pkg SHALL hold the state enum type and the constants LINE_W=256, BEAT_W=64 and BEATS=4.
REQ-037 The block SHALL have no sub-modules; the FSM, counter, and line/address registers are inline.

Verification
REQ-038 Read, ready=1, beats 0x11..,0x22..,0x33..,0x44.. consecutive at addr 0x0000_1020 -> bmem_read one cycle with addr 0x0000_1020; dfp_rdata={0x44..,0x33..,0x22..,0x11..}; dfp_resp one pulse.
REQ-039 Write of line L at addr 0x0000_2047, ready=1 -> bmem_addr 0x0000_2040 and beats L[63:0]..L[255:192] on 4 consecutive cycles; dfp_resp in cycle 5.
REQ-040 Write with bmem_ready toggling 1,0,1,0,... -> each beat held until accepted; exactly 4 accepted beats; dfp_resp after the 4th.
REQ-041 Read with a gap of 3 idle cycles between beats 1 and 2, plus one stray beat with wrong raddr -> stray beat ignored; line correct.
REQ-042 rst asserted after 2 read beats, then a new read -> no dfp_resp for the aborted read; new line correct with no stale beats.
REQ-043 dfp_write and dfp_read both 1 in IDLE, then the read held after RESP -> write burst first, then read accepted in the next IDLE cycle.
